// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache: 8 lines of 128 bits,
// zero-wait hits, and a three-state miss engine toward a line-wide memory port.
module l1_dcache (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] ALLOCATE  = 2'd2;

    logic [1:0]   state;
    logic [1:0]   state_next;
    logic [7:0]   valid;
    logic [7:0]   dirty;
    logic [8:0]   tags  [8];
    logic [127:0] lines [8];

    logic [8:0]   req_tag;
    logic [2:0]   idx;
    logic [2:0]   word_sel;
    logic         request;
    logic         hit;
    logic [127:0] cur_line;
    logic [127:0] merged_line;
    logic         write_hit;
    logic         fill_done;
    logic         unused_byte_offset;

    assign req_tag            = mem_address[15:7];
    assign idx                = mem_address[6:4];
    assign word_sel           = mem_address[3:1];
    assign unused_byte_offset = mem_address[0];

    assign request  = mem_read | mem_write;
    assign cur_line = lines[idx];
    assign hit      = valid[idx] && (tags[idx] == req_tag);

    always_comb begin
        merged_line = cur_line;
        if (mem_byte_enable[0])
            merged_line[{word_sel, 4'b0000} +: 8] = mem_wdata[7:0];
        if (mem_byte_enable[1])
            merged_line[{word_sel, 4'b1000} +: 8] = mem_wdata[15:8];
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a value held, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        mem_resp     = 1'b0;
        mem_rdata    = 16'h0000;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {req_tag, idx, 4'b0000};
        pmem_wdata   = cur_line;
        write_hit    = 1'b0;
        fill_done    = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    if (hit) begin
                        mem_resp  = 1'b1;
                        mem_rdata = cur_line[{word_sel, 4'b0000} +: 16];
                        write_hit = mem_write;
                    end else if (valid[idx] && dirty[idx]) begin
                        state_next = WRITEBACK;
                    end else begin
                        state_next = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tags[idx], idx, 4'b0000};
                if (pmem_resp)
                    state_next = ALLOCATE;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    fill_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A write with no byte enabled still completes but must not mark the line dirty.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= state_next;
            if (fill_done) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end else if (write_hit && (mem_byte_enable != 2'b00)) begin
                dirty[idx] <= 1'b1;
            end
        end
    end

    // NOTE: tag and data storage carry no reset; the valid bits alone decide
    // whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            lines[idx] <= pmem_rdata;
            tags[idx]  <= req_tag;
        end else if (write_hit) begin
            lines[idx] <= merged_line;
        end
    end

endmodule

// File: tb/tb_l1_dcache.sv
// Self-checking bench for l1_dcache: a cache-contents model plus a latency-programmable
// memory responder, with directed hit/miss/writeback/reset scenarios.
module tb_l1_dcache;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    l1_dcache dut (
        .clk            (clk),
        .reset          (reset),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_byte_enable(mem_byte_enable),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp),
        .pmem_address   (pmem_address),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Backing memory: explicit lines, else word i of a line reads as (line address + i).
    logic [127:0] mem_store [logic [15:0]];
    bit           log_wr   [$];
    logic [15:0]  log_addr [$];
    logic [127:0] log_data [$];

    function automatic logic [127:0] fetch(input logic [15:0] a);
        logic [127:0] r;
        if (mem_store.exists(a))
            return mem_store[a];
        for (int i = 0; i < 8; i++)
            r[i*16 +: 16] = a + 16'(i);
        return r;
    endfunction

    bit           mem_en   = 1'b1;
    int           mem_lat  = 3;
    int           mem_cnt  = 0;
    logic         man_resp = 1'b0;
    logic [127:0] man_data = '0;

    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_en) begin
                pmem_resp = 1'b0;
                if (pmem_read || pmem_write) begin
                    mem_cnt++;
                    if (mem_cnt >= mem_lat) begin
                        mem_cnt   = 0;
                        pmem_resp = 1'b1;
                        log_wr.push_back(pmem_write);
                        log_addr.push_back(pmem_address);
                        if (pmem_write) begin
                            mem_store[pmem_address] = pmem_wdata;
                            log_data.push_back(pmem_wdata);
                        end else begin
                            pmem_rdata = fetch(pmem_address);
                            log_data.push_back(pmem_rdata);
                        end
                    end
                end else begin
                    mem_cnt = 0;
                end
            end else begin
                mem_cnt    = 0;
                pmem_resp  = man_resp;
                pmem_rdata = man_data;
            end
        end
    end

    // Cache model: contents per index plus which memory transaction is owed.
    localparam int P_NONE = 0;
    localparam int P_WB   = 1;
    localparam int P_FILL = 2;

    logic         m_valid [8];
    logic         m_dirty [8];
    logic [8:0]   m_tag   [8];
    logic [127:0] m_line  [8];
    int           phase = P_NONE;
    bit           chk_en = 1'b0;

    logic [8:0] a_tag;
    logic [2:0] a_idx;
    logic [2:0] a_word;
    logic       m_hit;
    assign a_tag  = mem_address[15:7];
    assign a_idx  = mem_address[6:4];
    assign a_word = mem_address[3:1];
    assign m_hit  = m_valid[a_idx] && (m_tag[a_idx] == a_tag);

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                m_valid[i] = 1'b0;
                m_dirty[i] = 1'b0;
            end
            phase = P_NONE;
        end else begin
            case (phase)
                P_NONE: begin
                    if (mem_read || mem_write) begin
                        if (m_hit) begin
                            if (mem_write) begin
                                for (int b = 0; b < 2; b++)
                                    if (mem_byte_enable[b])
                                        m_line[a_idx][int'(a_word)*16 + b*8 +: 8] = mem_wdata[b*8 +: 8];
                                if (mem_byte_enable != 2'b00)
                                    m_dirty[a_idx] = 1'b1;
                            end
                        end else if (m_valid[a_idx] && m_dirty[a_idx]) begin
                            phase = P_WB;
                        end else begin
                            phase = P_FILL;
                        end
                    end
                end
                P_WB: if (pmem_resp) phase = P_FILL;
                default: begin
                    if (pmem_resp) begin
                        m_line[a_idx]  = pmem_rdata;
                        m_valid[a_idx] = 1'b1;
                        m_dirty[a_idx] = 1'b0;
                        m_tag[a_idx]   = a_tag;
                        phase          = P_NONE;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_hit;
            exp_hit = (phase == P_NONE) && (mem_read || mem_write) && m_hit;
            check("cyc_mem_resp", mem_resp, exp_hit);
            if (exp_hit && mem_read && !mem_write)
                check("cyc_mem_rdata", mem_rdata, m_line[a_idx][int'(a_word)*16 +: 16]);
            check("cyc_pmem_read", pmem_read, phase == P_FILL);
            check("cyc_pmem_write", pmem_write, phase == P_WB);
            if (phase == P_WB) begin
                check("cyc_wb_addr", pmem_address, {m_tag[a_idx], a_idx, 4'h0});
                check("cyc_wb_data", pmem_wdata, m_line[a_idx]);
            end
            if (phase == P_FILL)
                check("cyc_fill_addr", pmem_address, {a_tag, a_idx, 4'h0});
        end
    end

    // Issues one CPU request from just after a rising edge and waits for mem_resp.
    task automatic do_req(input logic [15:0] addr, input logic rd, input logic wr,
                          input logic [1:0] be, input logic [15:0] wd,
                          output int lat, output logic [15:0] rdata);
        mem_address     = addr;
        mem_read        = rd;
        mem_write       = wr;
        mem_byte_enable = be;
        mem_wdata       = wd;
        lat             = 0;
        rdata           = '0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (mem_resp) begin
                rdata = mem_rdata;
                break;
            end
            if (lat >= 100) begin
                checks++;
                failures++;
                $display("FAIL req_timeout addr=%0h cycles=%0d", addr, lat);
                break;
            end
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] rd;
        int          n0;

        reset           = 1'b1;
        mem_address     = 16'h0000;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b00;
        mem_wdata       = 16'h0000;
        mem_store[16'h0040] = {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                               16'h3333, 16'h2222, 16'h1234, 16'h0000};
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        check("reset_mem_resp", mem_resp, 1'b0);
        check("reset_pmem_read", pmem_read, 1'b0);
        check("reset_pmem_write", pmem_write, 1'b0);
        check("reset_rdata_known", $isunknown(mem_rdata), 1'b0);
        @(posedge clk);
        #1;

        // Cold read miss, clean allocate.
        n0 = log_wr.size();
        do_req(16'h0042, 1, 0, 2'b00, 16'h0, lat, rd);
        check("cold_latency", lat, 5);
        check("cold_rdata", rd, 16'h1234);
        check("cold_txn_count", log_wr.size(), n0 + 1);
        if (log_wr.size() == n0 + 1) begin
            check("cold_txn_is_read", log_wr[n0], 1'b0);
            check("cold_txn_addr", log_addr[n0], 16'h0040);
        end

        // Repeat read hits with no memory traffic.
        n0 = log_wr.size();
        do_req(16'h0042, 1, 0, 2'b00, 16'h0, lat, rd);
        check("hit_latency", lat, 1);
        check("hit_rdata", rd, 16'h1234);
        check("hit_no_pmem", log_wr.size(), n0);

        // Low-byte write then read-back.
        do_req(16'h0042, 0, 1, 2'b01, 16'hABCD, lat, rd);
        check("wr_lo_latency", lat, 1);
        do_req(16'h0042, 1, 0, 2'b00, 16'h0, lat, rd);
        check("wr_lo_readback", rd, 16'h12CD);

        // Conflict miss on a dirty line: writeback, then allocate.
        n0 = log_wr.size();
        do_req(16'h00C2, 1, 0, 2'b00, 16'h0, lat, rd);
        check("dirty_miss_latency", lat, 8);
        check("dirty_miss_rdata", rd, 16'h00C1);
        check("dirty_miss_txn_count", log_wr.size(), n0 + 2);
        if (log_wr.size() == n0 + 2) begin
            check("wb_is_write", log_wr[n0], 1'b1);
            check("wb_addr", log_addr[n0], 16'h0040);
            check("wb_line", log_data[n0], {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                                            16'h3333, 16'h2222, 16'h12CD, 16'h0000});
            check("fill_is_read", log_wr[n0+1], 1'b0);
            check("fill_addr", log_addr[n0+1], 16'h00C0);
        end

        // No byte enabled: responds, data and dirty untouched.
        do_req(16'h00C6, 0, 1, 2'b00, 16'hFFFF, lat, rd);
        check("be00_latency", lat, 1);
        do_req(16'h00C6, 1, 0, 2'b00, 16'h0, lat, rd);
        check("be00_readback", rd, 16'h00C3);
        do_req(16'h0046, 1, 0, 2'b00, 16'h0, lat, rd);
        check("be00_clean_miss_latency", lat, 5);
        check("be00_clean_miss_rdata", rd, 16'h3333);

        // Read and write together act as a write.
        do_req(16'h0046, 1, 1, 2'b11, 16'hBEEF, lat, rd);
        check("rdwr_latency", lat, 1);
        do_req(16'h0046, 1, 0, 2'b00, 16'h0, lat, rd);
        check("rdwr_readback", rd, 16'hBEEF);
        n0 = log_wr.size();
        do_req(16'h00C4, 1, 0, 2'b00, 16'h0, lat, rd);
        check("rdwr_dirty_latency", lat, 8);
        check("rdwr_dirty_rdata", rd, 16'h00C2);
        if (log_wr.size() >= n0 + 1)
            check("rdwr_wb_word3", log_data[n0][63:48], 16'hBEEF);

        // High-byte write.
        do_req(16'h00C4, 0, 1, 2'b10, 16'h5A77, lat, rd);
        do_req(16'h00C4, 1, 0, 2'b00, 16'h0, lat, rd);
        check("wr_hi_readback", rd, 16'h5AC2);

        // Request dropped mid-allocate: fill still lands, no response issued.
        mem_address = 16'h0150;
        mem_read    = 1'b1;
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        do_req(16'h0150, 1, 0, 2'b00, 16'h0, lat, rd);
        check("dropped_then_hit_latency", lat, 1);
        check("dropped_then_hit_rdata", rd, 16'h0150);

        // Make index 4 clean so the next 0x0042 read goes straight to allocate.
        do_req(16'h0242, 1, 0, 2'b00, 16'h0, lat, rd);
        check("clean_idx4_latency", lat, 8);
        check("clean_idx4_rdata", rd, 16'h0241);

        // Reset during allocate, then a stray memory response.
        mem_en      = 1'b0;
        mem_address = 16'h0042;
        mem_read    = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_alloc_pmem_read", pmem_read, 1'b1);
        check("rst_alloc_addr", pmem_address, 16'h0040);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        mem_read = 1'b0;
        man_data = {8{16'hDEAD}};
        man_resp = 1'b1;
        @(negedge clk);
        check("post_rst_pmem_read", pmem_read, 1'b0);
        check("post_rst_mem_resp", mem_resp, 1'b0);
        @(posedge clk);
        #1;
        man_resp = 1'b0;
        @(posedge clk);
        #1;
        mem_en = 1'b1;
        do_req(16'h0042, 1, 0, 2'b00, 16'h0, lat, rd);
        check("post_rst_miss_latency", lat, 5);
        check("post_rst_rdata", rd, 16'h12CD);
        do_req(16'h0150, 1, 0, 2'b00, 16'h0, lat, rd);
        check("post_rst_other_miss_latency", lat, 5);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1_dcache.md
L1_DCACHE -- requirements
Module: l1_dcache

Interface
REQ-001 SHALL use one clock `clk`; `reset` is synchronous and active-high.
REQ-002 Ports, CPU side; the cache is the responder on this interface:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- mem_address  in  16  byte address from MEM stage
- mem_read  in  1  read request, held until mem_resp
- mem_write  in  1  write request, held until mem_resp
- mem_byte_enable  in  2  bit1 = high byte, bit0 = low byte (write only)
- mem_wdata  in  16  write data
- mem_rdata  out  16  read data, valid while mem_resp=1
- mem_resp  out  1  request complete
REQ-003 Ports, memory side; the cache is the initiator on this interface:
- pmem_address  out  16  line-aligned address, [3:0]=0
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp
- pmem_wdata  out  128  writeback line
- pmem_rdata  in  128  fill line, valid with pmem_resp
- pmem_resp  in  1  memory transaction complete

Function
REQ-004 Organisation SHALL be direct-mapped, write-back, write-allocate, with 8 lines of 128 bits.
REQ-005 Address split SHALL be: tag=[15:7] (9b), index=[6:4] (3b), word=[3:1], byte=[0] (ignored).
REQ-006 Per-line state SHALL be valid, dirty and tag, all held in flip-flops; data SHALL be held in flip-flops.
REQ-007 The FSM SHALL have exactly three states: IDLE, WRITEBACK, ALLOCATE.
REQ-008 Request = mem_read | mem_write; hit = valid[index] & (tag[index]==addr tag).
REQ-009 IDLE, request and hit: mem_resp=1 combinationally in the same cycle (zero-wait hit), and the FSM SHALL stay in IDLE.
REQ-010 Read hit: mem_rdata = word [word*16 +: 16] of the indexed line.
REQ-011 Write hit, at the clock edge ending the cycle:
- update each byte whose enable bit=1; keep all other bytes
- set dirty[index]=1
- a byte_enable of 2'b00 still responds but changes neither data nor dirty
REQ-012 IDLE, request, miss, and (!valid | !dirty) at index: go to ALLOCATE next cycle; mem_resp=0.
REQ-013 IDLE, request, miss, valid & dirty at index: go to WRITEBACK next cycle; mem_resp=0.
REQ-014 WRITEBACK state:
- pmem_write=1
- pmem_address={stored tag,index,4'b0}
- pmem_wdata=indexed line
- hold these until pmem_resp=1, then go to ALLOCATE
REQ-015 ALLOCATE state:
- pmem_read=1 and pmem_address={request tag,index,4'b0}
- on pmem_resp=1: load the line from pmem_rdata, set valid=1, dirty=0, tag=request tag, then go to IDLE
REQ-016 After ALLOCATE, the request SHALL complete as a hit in IDLE on the following cycle; total miss latency = memory cycles + 2.
REQ-017 mem_resp SHALL be 0 in WRITEBACK and ALLOCATE; pmem_read and pmem_write SHALL be 0 in IDLE and never both 1.
REQ-018 pmem_resp SHALL be ignored in IDLE.
REQ-019 mem_read and mem_write both 1: the cache SHALL treat the request as a write.
REQ-020 Request dropped mid-miss: the current WRITEBACK/ALLOCATE SHALL complete; the FSM then returns to IDLE, and no mem_resp is issued if no request is present.
REQ-021 The request address SHALL be sampled combinationally each cycle; the requester holds address and data stable until mem_resp.

Reset
REQ-022 reset=1 at a clock edge SHALL force:
- state=IDLE
- all valid=0 and all dirty=0
- mem_resp=0, pmem_read=0, pmem_write=0 in the next cycle
REQ-023 Reset mid-miss SHALL abandon the transaction; no line state is updated by a later pmem_resp.
REQ-024 Tag and data contents SHALL be don't-care after reset, but mem_rdata SHALL be deterministic (0 reset value allowed).

Verification
REQ-025 Cold read of 0x0042: pmem_read=1 with pmem_address=0x0040; memory responds after 3 cycles with a line whose word1=0x1234 → one idle cycle, then mem_resp=1, mem_rdata=0x1234; hit at cycle 5.
REQ-026 Read 0x0042 again → mem_resp=1 the same cycle; no pmem activity.
REQ-027 Write 0x0042, data 0xABCD, byte_enable=2'b01 → resp in the same cycle; a following read returns 0x12CD; dirty[4]=1.
REQ-028 Read 0x00C2 (same index 4, tag differs) after REQ-027 → WRITEBACK to 0x0040 with word1=0x12CD, then ALLOCATE from 0x00C0, then mem_resp.
REQ-029 Assert reset during ALLOCATE, then deliver pmem_resp → no line becomes valid; re-reading 0x0042 misses again.
REQ-030 mem_read and mem_write both 1 on a hit → write applied, dirty set, single mem_resp pulse.
